uart_rx_pixel: RTL and testbench
================================

// Module: uart_rx_pixel
// PURPOSE
//  Receive side of the FPGA<->NANO 12-bit pixel UART link. Deserialises 8N1 frames
//  from rx_port and pairs them (high byte, then low byte) into one 12-bit RGB pixel.
//  Presents the pixel with a single-cycle valid strobe to the downstream pixel sink.
//  Detects framing errors and drops a half-received pixel after an inter-byte timeout.
// PARAMETERS
//  CLOCK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD_RATE     9600        line bit rate
//  BAUD_DIV      CLOCK_FREQ/BAUD_RATE  clocks per bit (5208 at defaults)
//  TIMEOUT_BITS  20          bit periods allowed between end of high byte and start of low byte
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high
//  rx_port      in   1   UART RX line, asynchronous, idle high
//  pixel        out  12  last assembled pixel; held until next pixel_valid
//  pixel_valid  out  1   1-cycle strobe: pixel updated this cycle
//  frame_err    out  1   1-cycle strobe: stop bit sampled low
//  busy         out  1   high while a frame is in progress or a high byte awaits its low byte
// BEHAVIOUR
//  - Reset: pixel=0, pixel_valid=0, frame_err=0, busy=0; both FSMs to idle; all counters 0.
//    Reset mid-frame aborts; any partial byte/pixel is discarded.
//  - rx_port passes a 2-FF synchroniser (reset value 1) before any use.
//  - Byte FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//    IDLE: on synced falling edge load bit counter with BAUD_DIV/2-1, go START.
//    START: at count expiry resample; still 0 -> DATA (counter BAUD_DIV-1); 1 -> IDLE (glitch).
//    DATA: sample every BAUD_DIV clocks (mid-bit), 8 bits LSB first into shift reg, then STOP.
//    STOP: sample mid-stop; 1 -> byte_valid strobe; 0 -> frame_err strobe, byte dropped,
//      stay in STOP until line reads 1, then IDLE (no false start on a held-low line).
//    No mid-bit majority voting; single sample per bit.
//  - Pair assembler: WAIT_HIGH / WAIT_LOW.
//    WAIT_HIGH + byte_valid: hi_reg <= byte, go WAIT_LOW, clear timeout counter.
//    WAIT_LOW + byte_valid: pixel <= {hi_reg, byte[7:4]}, pixel_valid=1, go WAIT_HIGH.
//      byte[3:0] ignored (sender pads with 0; non-zero is not an error).
//    WAIT_LOW: timeout counter runs only while byte FSM is IDLE; reaching
//      TIMEOUT_BITS*BAUD_DIV -> WAIT_HIGH, hi_reg discarded, no strobe.
//    frame_err in either state -> WAIT_HIGH (resync on next byte).
//  - Latency: byte_valid one clock after mid-stop sample; pixel_valid one clock after
//    byte_valid of the low byte. Back-to-back frames (next start immediately after stop
//    midpoint) must be accepted.
//  - busy = (byte FSM != IDLE) | (assembler == WAIT_LOW).
//  - Counter widths: $clog2(BAUD_DIV) bits for bit timing, $clog2(TIMEOUT_BITS*BAUD_DIV+1)
//    for timeout; no wrap possible before expiry.
// STRUCTURE
//  - uart_pkg: rx byte-FSM enum, assembler enum, default CLOCK_FREQ/BAUD_RATE constants
//    (shared with the TX side).
//  - Sub-module uart_rx_byte: synchroniser + byte FSM -> byte[7:0], byte_valid, frame_err,
//    rx_active. Top level holds pair assembler, timeout counter, output registers.
// TESTING (sim with CLOCK_FREQ=160_000, BAUD_RATE=10_000 -> BAUD_DIV=16)
//  1. frames 0xAB,0xC0 -> pixel=0xABC, pixel_valid high exactly 1 clk, busy low afterwards.
//  2. back-to-back 0xFF,0xF0,0x00,0x00 no idle gap -> two strobes: 0xFFF then 0x000.
//  3. rx low 4 clks then high -> no byte, no strobe, frame_err stays 0, busy returns 0.
//  4. 0x12 with stop=0, then 0x12,0x30 -> one frame_err strobe, then pixel=0x123 once.
//  5. 0x99, idle 25 bit times, then 0x45,0x6F -> no strobe for 0x99; pixel=0x456.
//  6. reset during data bit 4 of high byte -> outputs 0; next 0x5A,0x70 -> pixel=0x5A7.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the FPGA<->NANO pixel link: FSM state types and
// default line timing constants used by both the RX and TX sides.
package uart_pkg;

   localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
   localparam int DEFAULT_BAUD_RATE  = 9600;

   // RX_BREAK holds off after a framing error until the line returns high
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   typedef enum logic {
      ASM_WAIT_HIGH,
      ASM_WAIT_LOW
   } asm_state_t;

   function automatic int baudDivisor(input int clockFreq, input int baudRate);
      return clockFreq / baudRate;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser on the RX line, single mid-bit sample
// per bit, registered byte-valid and framing-error strobes.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byteValid,
   output logic       o_frameErr,
   output logic       o_rxActive
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_rxPrev;
   rx_state_t     r_state;
   rx_state_t     w_nextState;
   logic [CW-1:0] r_bitTimer;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shift;
   logic          r_byteValid;
   logic          r_frameErr;
   logic          w_fallEdge;
   logic          w_tick;

   assign w_fallEdge = r_rxPrev & ~r_sync2;
   assign w_tick     = (r_bitTimer == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_rxPrev <= 1'b1;
      end else begin
         r_sync1  <= i_rx;
         r_sync2  <= r_sync1;
         r_rxPrev <= r_sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= RX_IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         RX_IDLE:  if (w_fallEdge) w_nextState = RX_START;
         RX_START: if (w_tick) w_nextState = r_sync2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick && r_bitIdx == 3'd7) w_nextState = RX_STOP;
         RX_STOP:  if (w_tick) w_nextState = r_sync2 ? RX_IDLE : RX_BREAK;
         RX_BREAK: if (r_sync2) w_nextState = RX_IDLE;
         default:  w_nextState = RX_IDLE;
      endcase
   end

   // Bit timer counts down to zero; every expiry is a mid-bit sample point
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bitTimer  <= '0;
         r_bitIdx    <= '0;
         r_shift     <= '0;
         r_byteValid <= 1'b0;
         r_frameErr  <= 1'b0;
      end else begin
         r_byteValid <= 1'b0;
         r_frameErr  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               if (w_fallEdge) r_bitTimer <= HALF_LOAD;
            end
            RX_START: begin
               if (w_tick) begin
                  r_bitTimer <= FULL_LOAD;
                  r_bitIdx   <= '0;
               end else begin
                  r_bitTimer <= r_bitTimer - 1'b1;
               end
            end
            RX_DATA: begin
               if (w_tick) begin
                  r_shift    <= {r_sync2, r_shift[7:1]};
                  r_bitIdx   <= r_bitIdx + 1'b1;
                  r_bitTimer <= FULL_LOAD;
               end else begin
                  r_bitTimer <= r_bitTimer - 1'b1;
               end
            end
            RX_STOP: begin
               if (w_tick) begin
                  r_byteValid <= r_sync2;
                  r_frameErr  <= ~r_sync2;
               end else begin
                  r_bitTimer <= r_bitTimer - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_byte      = r_shift;
   assign o_byteValid = r_byteValid;
   assign o_frameErr  = r_frameErr;
   assign o_rxActive  = (r_state != RX_IDLE);

endmodule

// File: rtl/uart_rx_pixel.sv
// Pixel-link receiver: pairs received bytes (high, then low) into a 12-bit RGB
// pixel, dropping a lone high byte when its partner does not arrive in time.
module uart_rx_pixel
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ   = DEFAULT_CLOCK_FREQ,
   parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_port,
   output logic [11:0] pixel,
   output logic        pixel_valid,
   output logic        frame_err,
   output logic        busy
);

   localparam int BAUD_DIV     = baudDivisor(CLOCK_FREQ, BAUD_RATE);
   localparam int TIMEOUT_CLKS = TIMEOUT_BITS * BAUD_DIV;
   localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CLKS);

   logic [7:0]    w_byte;
   logic          w_byteValid;
   logic          w_frameErr;
   logic          w_rxActive;
   logic          w_timeout;
   asm_state_t    r_asm;
   asm_state_t    w_nextAsm;
   logic [7:0]    r_hiByte;
   logic [11:0]   r_pixel;
   logic          r_pixelValid;
   logic [TW-1:0] r_timeout;

   uart_rx_byte #(
      .BAUD_DIV(BAUD_DIV)
   ) u_rxByte (
      .clk        (clk),
      .reset      (reset),
      .i_rx       (rx_port),
      .o_byte     (w_byte),
      .o_byteValid(w_byteValid),
      .o_frameErr (w_frameErr),
      .o_rxActive (w_rxActive)
   );

   assign w_timeout = (r_timeout == TIMEOUT_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) r_asm <= ASM_WAIT_HIGH;
      else       r_asm <= w_nextAsm;
   end

   // A framing error always resynchronises: the next good byte is a high byte
   always_comb begin
      w_nextAsm = r_asm;
      if (w_frameErr) begin
         w_nextAsm = ASM_WAIT_HIGH;
      end else begin
         case (r_asm)
            ASM_WAIT_HIGH: if (w_byteValid) w_nextAsm = ASM_WAIT_LOW;
            ASM_WAIT_LOW:  if (w_byteValid || w_timeout) w_nextAsm = ASM_WAIT_HIGH;
            default:       w_nextAsm = ASM_WAIT_HIGH;
         endcase
      end
   end

   // Timeout only counts idle line time, so a slow low byte in flight is not cut off
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hiByte     <= '0;
         r_pixel      <= '0;
         r_pixelValid <= 1'b0;
         r_timeout    <= '0;
      end else begin
         r_pixelValid <= 1'b0;
         case (r_asm)
            ASM_WAIT_HIGH: begin
               if (w_byteValid) begin
                  r_hiByte  <= w_byte;
                  r_timeout <= '0;
               end
            end
            ASM_WAIT_LOW: begin
               if (w_byteValid) begin
                  r_pixel      <= {r_hiByte, w_byte[7:4]};
                  r_pixelValid <= 1'b1;
               end else if (!w_rxActive && !w_timeout) begin
                  r_timeout <= r_timeout + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pixel       = r_pixel;
   assign pixel_valid = r_pixelValid;
   assign frame_err   = w_frameErr;
   assign busy        = w_rxActive | (r_asm == ASM_WAIT_LOW);

endmodule

// File: tb/tb_uart_rx_pixel.sv
// Self-checking bench for uart_rx_pixel: serialises 8N1 frames onto rx_port and
// compares each pixel strobe against a queue of expected pixels.
module tb_uart_rx_pixel;

   localparam int CLK_FREQ = 160_000;
   localparam int BAUD     = 10_000;
   localparam int BIT_CLKS = 16;

   typedef struct {
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [11:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_port;
   logic [11:0] pixel;
   logic        pixel_valid;
   logic        frame_err;
   logic        busy;

   int          nCompared   = 0;
   int          nMismatched = 0;
   int          frameErrCount = 0;
   logic        prevValid = 1'b0;
   logic        prevErr   = 1'b0;
   logic [11:0] expQ[$];
   vec_t        vectors[5];
   int          errBefore;

   always #5 clk = ~clk;

   uart_rx_pixel #(
      .CLOCK_FREQ  (CLK_FREQ),
      .BAUD_RATE   (BAUD),
      .TIMEOUT_BITS(20)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_port    (rx_port),
      .pixel      (pixel),
      .pixel_valid(pixel_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   function automatic void checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endfunction

   // Scoreboard side: every strobe pops one expected pixel; strobes must be 1 clk wide
   always @(negedge clk) begin
      if (!reset) begin
         if (pixel_valid) begin
            if (expQ.size() == 0) checkOutput("pixelUnexpected", int'(pixel_valid), 0);
            else                  checkOutput("pixel", int'(pixel), int'(expQ.pop_front()));
         end
         if (prevValid) checkOutput("validWidth", int'(pixel_valid), 0);
         if (prevErr)   checkOutput("errWidth", int'(frame_err), 0);
         if (frame_err) frameErrCount++;
      end
      prevValid = pixel_valid & ~reset;
      prevErr   = frame_err & ~reset;
   end

   task automatic holdLine(input logic level, input int clks);
      rx_port = level;
      repeat (clks) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int gapBits);
      logic [7:0] d;
      d = data;
      holdLine(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) holdLine(d[i], BIT_CLKS);
      holdLine(stopBit, BIT_CLKS);
      if (gapBits > 0) holdLine(1'b1, gapBits * BIT_CLKS);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
      checkOutput(name, expQ.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors[0] = '{hi: 8'hAB, lo: 8'hC0, exp: 12'hABC};
      vectors[1] = '{hi: 8'h12, lo: 8'h34, exp: 12'h123};
      vectors[2] = '{hi: 8'h00, lo: 8'h0F, exp: 12'h000};
      vectors[3] = '{hi: 8'h80, lo: 8'h10, exp: 12'h801};
      vectors[4] = '{hi: 8'h3C, lo: 8'hA5, exp: 12'h3CA};

      reset   = 1'b1;
      rx_port = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("resetPixel", int'(pixel), 0);
      checkOutput("resetValid", int'(pixel_valid), 0);
      checkOutput("resetErr", int'(frame_err), 0);
      checkOutput("resetBusy", int'(busy), 0);
      reset = 1'b0;
      holdLine(1'b1, 2 * BIT_CLKS);

      // 1: basic pair
      expQ.push_back(12'hABC);
      applyStimulus(8'hAB, 1'b1, 0);
      applyStimulus(8'hC0, 1'b1, 2);
      waitDrain("t1Drain");
      checkOutput("t1Busy", int'(busy), 0);
      checkOutput("t1Held", int'(pixel), 12'hABC);

      for (int v = 0; v < 5; v++) begin
         expQ.push_back(vectors[v].exp);
         applyStimulus(vectors[v].hi, 1'b1, 1);
         applyStimulus(vectors[v].lo, 1'b1, 2);
         waitDrain("tableDrain");
         checkOutput("tableBusy", int'(busy), 0);
      end

      // 2: back-to-back frames with no idle gap
      expQ.push_back(12'hFFF);
      expQ.push_back(12'h000);
      applyStimulus(8'hFF, 1'b1, 0);
      applyStimulus(8'hF0, 1'b1, 0);
      applyStimulus(8'h00, 1'b1, 0);
      applyStimulus(8'h00, 1'b1, 2);
      waitDrain("t2Drain");

      // 3: short glitch is not a start bit
      errBefore = frameErrCount;
      holdLine(1'b0, 4);
      holdLine(1'b1, 3 * BIT_CLKS);
      checkOutput("t3Busy", int'(busy), 0);
      checkOutput("t3Err", frameErrCount - errBefore, 0);

      // 4: bad stop bit, then a good pair
      errBefore = frameErrCount;
      applyStimulus(8'h12, 1'b0, 2);
      checkOutput("t4ErrCount", frameErrCount - errBefore, 1);
      checkOutput("t4Busy", int'(busy), 0);
      expQ.push_back(12'h123);
      applyStimulus(8'h12, 1'b1, 1);
      applyStimulus(8'h30, 1'b1, 2);
      waitDrain("t4Drain");

      // 5: lone high byte times out
      applyStimulus(8'h99, 1'b1, 2);
      checkOutput("t5BusyWaiting", int'(busy), 1);
      holdLine(1'b1, 23 * BIT_CLKS);
      checkOutput("t5BusyTimedOut", int'(busy), 0);
      expQ.push_back(12'h456);
      applyStimulus(8'h45, 1'b1, 1);
      applyStimulus(8'h6F, 1'b1, 2);
      waitDrain("t5Drain");

      // 6: reset in the middle of data bit 4
      holdLine(1'b0, BIT_CLKS);
      holdLine(1'b1, BIT_CLKS);
      holdLine(1'b0, BIT_CLKS);
      holdLine(1'b0, BIT_CLKS);
      holdLine(1'b1, BIT_CLKS);
      holdLine(1'b1, BIT_CLKS / 2);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      holdLine(1'b1, 2 * BIT_CLKS);
      checkOutput("t6Pixel", int'(pixel), 0);
      checkOutput("t6Busy", int'(busy), 0);
      checkOutput("t6Valid", int'(pixel_valid), 0);
      expQ.push_back(12'h5A7);
      applyStimulus(8'h5A, 1'b1, 1);
      applyStimulus(8'h70, 1'b1, 2);
      waitDrain("t6Drain");
      checkOutput("t6Final", int'(pixel), 12'h5A7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
